// File: rtl/frog_pkg.sv
// Shared types and playfield constants for the frog controller and pixel generator.
// The hold-repeat option is enabled with FROG_HOLD_REPEAT_EN.
package frog_pkg;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    typedef enum logic [1:0] {IDLE, HOP, DEAD, HOME} ctrl_state_t;

    localparam int CELL_PX     = 32;
    localparam int FIELD_X_MIN = 96;
    localparam int FIELD_X_MAX = 544;

    // Observation bundle: FSM state, pending slot and synchronized button levels.
    typedef struct packed {
        ctrl_state_t state;
        logic        pend_valid;
        dir_t        pend_dir;
        logic [3:0]  btn_lvl;
    } frog_dbg_t;

    // Bit order of p follows dir_t; lower index wins (up > down > left > right).
    function automatic dir_t prio_dir(input logic [3:0] p);
        if (p[0]) return DIR_UP;
        else if (p[1]) return DIR_DOWN;
        else if (p[2]) return DIR_LEFT;
        else return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/frog_if.sv
// Frog controller bus: frame/button/collision inputs and position/status outputs
// toward the pixel generator.
interface frog_if;
    // No valid/ready handshake: frame_tick is a one-clk strobe that qualifies hit,
    // and every output is a registered level that changes only on the clk after
    // a frame_tick (home_pulse is a one-clk strobe).
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       hit;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [9:0] frog_size;
    logic       hopping;
    logic       dead;
    logic [7:0] score;
    logic       home_pulse;

    modport master (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, hit,
        output frog_x, frog_y, frog_size, hopping, dead, score, home_pulse
    );

    modport slave (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, hit,
        input  frog_x, frog_y, frog_size, hopping, dead, score, home_pulse
    );
endinterface

// File: rtl/frog_btn_sync_edge.sv
// Two-flop synchronizer for one raw button plus a one-clk rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);
    logic ff1, ff2, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1  <= 1'b0;
            ff2  <= 1'b0;
            prev <= 1'b0;
        end else begin
            ff1  <= btn;
            ff2  <= ff1;
            prev <= ff2;
        end
    end

    assign level = ff2;
    assign rise  = ff2 & ~prev;
endmodule

// File: rtl/frog_ctrl.sv
// Frog motion controller: grid hops on frame_tick, death/respawn timer, home scoring.
// Optional FROG_HOLD_REPEAT_EN turns a held button into periodic synthetic presses.
module frog_ctrl
    import frog_pkg::*;
#(
    parameter int CELL         = CELL_PX,
    parameter int HOP_FRAMES   = 4,
    parameter int X_MIN        = FIELD_X_MIN,
    parameter int X_MAX        = FIELD_X_MAX,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 480,
    parameter int START_X      = 320,
    parameter int START_Y      = 448,
    parameter int DEATH_FRAMES = 30
`ifdef FROG_HOLD_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 8
`endif
) (
    input  logic      clk,
    input  logic      rst_n,
    frog_if.master    bus,
    output frog_dbg_t dbg
);
    // HOP_FRAMES must be at least 2: the first step is taken on the tick that enters HOP.
    localparam int STEP     = CELL / HOP_FRAMES;
    localparam int HOP_CW   = $clog2(HOP_FRAMES + 1);
    localparam int DEATH_CW = $clog2(DEATH_FRAMES + 1);

    localparam logic signed [10:0] CELL_S = 11'(CELL);
    localparam logic signed [10:0] X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] X_HI   = 11'(X_MAX - CELL);
    localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - CELL);

    logic [3:0] btn_raw, btn_lvl, btn_rise, press;

    assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .level (btn_lvl[i]),
            .rise  (btn_rise[i])
        );
    end

`ifdef FROG_HOLD_REPEAT_EN
    localparam int RPT_CW = $clog2(REPEAT_FRAMES + 1);
    logic [RPT_CW-1:0] hold_cnt [4];
    logic [3:0]        synth;

    always_comb begin
        synth = '0;
        for (int i = 0; i < 4; i++)
            synth[i] = bus.frame_tick && btn_lvl[i] &&
                       (hold_cnt[i] == RPT_CW'(REPEAT_FRAMES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!btn_lvl[i])     hold_cnt[i] <= '0;
                else if (synth[i])   hold_cnt[i] <= '0;
                else if (bus.frame_tick) hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end

    assign press = btn_rise | synth;
`else
    assign press = btn_rise;
`endif

    ctrl_state_t         state, state_n;
    logic                pend_valid, pend_valid_n;
    dir_t                pend_dir, pend_dir_n;
    dir_t                hop_dir, hop_dir_n;
    logic [HOP_CW-1:0]   hop_cnt, hop_cnt_n;
    logic [DEATH_CW-1:0] death_cnt, death_cnt_n;
    logic [9:0]          frog_x, frog_x_n, frog_y, frog_y_n;
    logic [7:0]          score, score_n;
    logic                home_pulse, home_pulse_n;

    logic signed [10:0] tx, ty;
    logic               legal;
    dir_t               step_dir;
    logic [9:0]         step_x, step_y;

    // Target of the pending move, in signed arithmetic so a move past 0 is caught.
    always_comb begin
        tx = signed'({1'b0, frog_x});
        ty = signed'({1'b0, frog_y});
        case (pend_dir)
            DIR_UP:    ty = ty - CELL_S;
            DIR_DOWN:  ty = ty + CELL_S;
            DIR_LEFT:  tx = tx - CELL_S;
            default:   tx = tx + CELL_S;
        endcase
        legal = (tx >= X_LO) && (tx <= X_HI) && (ty >= Y_LO) && (ty <= Y_HI);
    end

    // One sub-step; from IDLE it uses the pending direction (hop start).
    always_comb begin
        step_dir = (state == HOP) ? hop_dir : pend_dir;
        step_x   = frog_x;
        step_y   = frog_y;
        case (step_dir)
            DIR_UP:    step_y = frog_y - 10'(STEP);
            DIR_DOWN:  step_y = frog_y + 10'(STEP);
            DIR_LEFT:  step_x = frog_x - 10'(STEP);
            default:   step_x = frog_x + 10'(STEP);
        endcase
    end

    always_comb begin
        state_n      = state;
        pend_valid_n = pend_valid;
        pend_dir_n   = pend_dir;
        hop_dir_n    = hop_dir;
        hop_cnt_n    = hop_cnt;
        death_cnt_n  = death_cnt;
        frog_x_n     = frog_x;
        frog_y_n     = frog_y;
        score_n      = score;
        home_pulse_n = 1'b0;

        if (bus.frame_tick) begin
            case (state)
                IDLE: begin
                    if (bus.hit) begin
                        state_n      = DEAD;
                        pend_valid_n = 1'b0;
                        death_cnt_n  = '0;
                    end else if (pend_valid) begin
                        pend_valid_n = 1'b0;
                        if (legal) begin
                            state_n   = HOP;
                            hop_dir_n = pend_dir;
                            hop_cnt_n = '0;
                            frog_x_n  = step_x;
                            frog_y_n  = step_y;
                        end
                    end
                end
                HOP: begin
                    if (bus.hit) begin
                        state_n      = DEAD;
                        pend_valid_n = 1'b0;
                        death_cnt_n  = '0;
                    end else begin
                        frog_x_n  = step_x;
                        frog_y_n  = step_y;
                        hop_cnt_n = hop_cnt + 1'b1;
                        if (hop_cnt == HOP_CW'(HOP_FRAMES - 2)) begin
                            hop_cnt_n = '0;
                            state_n   = (step_y == 10'(Y_MIN)) ? HOME : IDLE;
                        end
                    end
                end
                DEAD: begin
                    if (death_cnt == DEATH_CW'(DEATH_FRAMES - 1)) begin
                        death_cnt_n = '0;
                        frog_x_n    = 10'(START_X);
                        frog_y_n    = 10'(START_Y);
                        state_n     = IDLE;
                    end else begin
                        death_cnt_n = death_cnt + 1'b1;
                    end
                end
                default: begin
                    frog_x_n = 10'(START_X);
                    frog_y_n = 10'(START_Y);
                    state_n  = IDLE;
                    if (score != 8'hFF) begin
                        score_n      = score + 8'd1;
                        home_pulse_n = 1'b1;
                    end
                end
            endcase
        end

        // A press lands after any hop-start clear, so it refills the slot on that clk.
        if (|press && (state == IDLE || state == HOP) &&
            (state_n == IDLE || state_n == HOP)) begin
            pend_valid_n = 1'b1;
            pend_dir_n   = prio_dir(press);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_dir   <= DIR_UP;
            hop_dir    <= DIR_UP;
            hop_cnt    <= '0;
            death_cnt  <= '0;
            frog_x     <= 10'(START_X);
            frog_y     <= 10'(START_Y);
            score      <= '0;
            home_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            pend_valid <= pend_valid_n;
            pend_dir   <= pend_dir_n;
            hop_dir    <= hop_dir_n;
            hop_cnt    <= hop_cnt_n;
            death_cnt  <= death_cnt_n;
            frog_x     <= frog_x_n;
            frog_y     <= frog_y_n;
            score      <= score_n;
            home_pulse <= home_pulse_n;
        end
    end

    assign bus.frog_x     = frog_x;
    assign bus.frog_y     = frog_y;
    assign bus.frog_size  = 10'(CELL);
    assign bus.hopping    = (state == HOP);
    assign bus.dead       = (state == DEAD);
    assign bus.score      = score;
    assign bus.home_pulse = home_pulse;

    assign dbg.state      = state;
    assign dbg.pend_valid = pend_valid;
    assign dbg.pend_dir   = pend_dir;
    assign dbg.btn_lvl    = btn_lvl;
endmodule
